// File: rtl/evo_pwm_bank_pkg.sv
// Shared types, CSR register offsets and pulse-width helpers for the evo_pwm_bank servo/PWM bank.
// Optional pin-readback fault detection is enabled with EVO_PWM_BANK_FAULT_EN.
package evo_pwm_bank_pkg;

    typedef logic [11:0] pw_t;

    localparam logic [2:0] REG_SEL    = 3'd0;
    localparam logic [2:0] REG_TARGET = 3'd1;
    localparam logic [2:0] REG_STEP   = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_CUR    = 3'd4;
    localparam logic [2:0] REG_FRAME  = 3'd5;

    localparam pw_t MIN_US   = 12'd500;
    localparam pw_t MAX_US   = 12'd2500;
    localparam pw_t RESET_US = 12'd1500;

    function automatic pw_t clamp_pw(input logic [31:0] v);
        pw_t r;
        if (v < 32'(MIN_US)) begin
            r = MIN_US;
        end else if (v > 32'(MAX_US)) begin
            r = MAX_US;
        end else begin
            r = v[11:0];
        end
        return r;
    endfunction

    // One frame of slew: move cur toward tgt by at most step; step 0 jumps.
    function automatic pw_t ramp_pw(input pw_t cur, input pw_t tgt, input pw_t step);
        pw_t diff;
        pw_t r;
        diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if (step == '0 || diff <= step) begin
            r = tgt;
        end else if (tgt > cur) begin
            r = cur + step;
        end else begin
            r = cur - step;
        end
        return r;
    endfunction

endpackage

// File: rtl/evo_pwm_bank_ch.sv
// One PWM channel: TARGET/STEP/EN registers, frame-synchronous ramp, pulse compare.
// With EVO_PWM_BANK_FAULT_EN defined, pin readback mismatches latch a sticky FAULT.
module evo_pwm_bank_ch
    import evo_pwm_bank_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en1mhz_i,
    input  logic        frame_start_i,
    input  logic [15:0] frame_cnt_i,
    input  logic        wr_target_i,
    input  logic        wr_step_i,
    input  logic        wr_ctrl_i,
    input  logic [31:0] wdata_i,
    input  logic        pin_i,
    output logic [11:0] target_o,
    output logic [11:0] step_o,
    output logic [11:0] cur_o,
    output logic        en_o,
    output logic        busy_o,
    output logic        fault_o,
    output logic        en_act_o,
    output logic        out_o
);

    pw_t  target_q, target_d;
    pw_t  step_q, step_d;
    pw_t  cur_q, cur_d;
    logic en_q, en_d;
    logic en_act_q, en_act_d;
    logic out_q, out_d;
    logic fault_w;
    logic kill_w;

`ifdef EVO_PWM_BANK_FAULT_EN
    logic [1:0] sync_q;
    logic [1:0] hist_q;
    logic [1:0] mm_cnt_q;
    logic       fault_q;

    // hist_q[1] is the level driven two en1mhz ticks ago, compared to the synced pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            hist_q   <= '0;
            mm_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            if (en1mhz_i) begin
                hist_q <= {hist_q[0], out_q};
                if (en_act_q && (sync_q[1] != hist_q[1])) begin
                    mm_cnt_q <= (mm_cnt_q == 2'd3) ? 2'd3 : mm_cnt_q + 2'd1;
                end else begin
                    mm_cnt_q <= '0;
                end
            end
            if (mm_cnt_q == 2'd3) begin
                fault_q  <= 1'b1;
                mm_cnt_q <= '0;
            end else if (wr_ctrl_i && wdata_i[2]) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign fault_w = fault_q;
    assign kill_w  = (mm_cnt_q == 2'd3);
`else
    logic unused_fault_inputs;
    assign unused_fault_inputs = pin_i ^ en1mhz_i;
    assign fault_w = 1'b0;
    assign kill_w  = 1'b0;
`endif

    always_comb begin
        target_d = target_q;
        step_d   = step_q;
        en_d     = en_q;
        cur_d    = cur_q;
        en_act_d = en_act_q;
        if (wr_target_i) begin
            target_d = clamp_pw(wdata_i);
        end
        if (wr_step_i) begin
            step_d = wdata_i[11:0];
        end
        if (wr_ctrl_i) begin
            en_d = wdata_i[0];
        end
        if (frame_start_i) begin
            en_act_d = en_q & ~fault_w & ~kill_w;
            cur_d    = ramp_pw(cur_q, target_q, step_q);
        end else if (kill_w) begin
            en_act_d = 1'b0;
        end
        out_d = en_act_q & (frame_cnt_i < {4'b0, cur_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= RESET_US;
            step_q   <= '0;
            cur_q    <= RESET_US;
            en_q     <= 1'b0;
            en_act_q <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            step_q   <= step_d;
            cur_q    <= cur_d;
            en_q     <= en_d;
            en_act_q <= en_act_d;
            out_q    <= out_d;
        end
    end

    assign target_o = target_q;
    assign step_o   = step_q;
    assign cur_o    = cur_q;
    assign en_o     = en_q;
    assign busy_o   = (cur_q != target_q);
    assign fault_o  = fault_w;
    assign en_act_o = en_act_q;
    assign out_o    = out_q & en_act_q;

endmodule

// File: rtl/evo_pwm_bank.sv
// Multi-channel servo/PWM bank: Avalon-MM CSR decode, channel select, frame counter, readback.
// Define EVO_PWM_BANK_FAULT_EN to enable per-channel pin readback fault detection.
module evo_pwm_bank
    import evo_pwm_bank_pkg::*;
#(
    parameter int unsigned            NUM_CH     = 16,
    parameter int unsigned            CSR_AWIDTH = 6,
    parameter int unsigned            CSR_DWIDTH = 32,
    parameter logic [CSR_AWIDTH-1:0]  BASE_ADDR  = CSR_AWIDTH'('h20),
    parameter int unsigned            FRAME_US   = 20000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en1mhz,
    output logic [NUM_CH-1:0]     pmux_dir_o,
    output logic [NUM_CH-1:0]     pmux_out_o,
    output logic [NUM_CH-1:0]     pmux_en_o,
    input  logic [NUM_CH-1:0]     pmux_in_i,
    input  logic [CSR_AWIDTH-1:0] avs_csr_address,
    input  logic                  avs_csr_read,
    input  logic                  avs_csr_write,
    input  logic [CSR_DWIDTH-1:0] avs_csr_writedata,
    output logic [CSR_DWIDTH-1:0] avs_csr_readdata,
    output logic                  avs_csr_readdatavalid,
    output logic                  avs_csr_waitrequest
);

    localparam logic [15:0] FRAME_LAST = 16'(FRAME_US - 1);

    logic [CSR_AWIDTH-1:0] off;
    logic                  hit;
    logic [2:0]            reg_idx;
    logic [31:0]           wdata32;
    logic                  sel_valid;

    logic [4:0]  sel_q, sel_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] frame_num_q, frame_num_d;
    logic        frame_start;

    logic [CSR_DWIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic [31:0]           rd_word;

    logic [11:0] ch_target [NUM_CH];
    logic [11:0] ch_step   [NUM_CH];
    logic [11:0] ch_cur    [NUM_CH];
    logic [NUM_CH-1:0] ch_en, ch_busy, ch_fault, ch_en_act, ch_out;

    pw_t  sel_target, sel_step, sel_cur;
    logic sel_en, sel_busy, sel_fault;

    // Address wraps below BASE_ADDR to a large offset, so one compare covers the window.
    assign off       = avs_csr_address - BASE_ADDR;
    assign hit       = (off < CSR_AWIDTH'(6));
    assign reg_idx   = off[2:0];
    assign wdata32   = 32'(avs_csr_writedata);
    assign sel_valid = (32'(sel_q) < NUM_CH);

    always_comb begin
        sel_d = sel_q;
        if (avs_csr_write && hit && reg_idx == REG_SEL) begin
            sel_d = wdata32[4:0];
        end
        frame_start = en1mhz && (frame_cnt_q == FRAME_LAST);
        frame_cnt_d = frame_cnt_q;
        frame_num_d = frame_num_q;
        if (en1mhz) begin
            if (frame_start) begin
                frame_cnt_d = '0;
                frame_num_d = frame_num_q + 16'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic wr_me;
        assign wr_me = avs_csr_write && hit && sel_valid && (sel_q == 5'(g));

        evo_pwm_bank_ch u_ch (
            .clk           (clk),
            .rst           (reset),
            .en1mhz_i      (en1mhz),
            .frame_start_i (frame_start),
            .frame_cnt_i   (frame_cnt_q),
            .wr_target_i   (wr_me && reg_idx == REG_TARGET),
            .wr_step_i     (wr_me && reg_idx == REG_STEP),
            .wr_ctrl_i     (wr_me && reg_idx == REG_CTRL),
            .wdata_i       (wdata32),
            .pin_i         (pmux_in_i[g]),
            .target_o      (ch_target[g]),
            .step_o        (ch_step[g]),
            .cur_o         (ch_cur[g]),
            .en_o          (ch_en[g]),
            .busy_o        (ch_busy[g]),
            .fault_o       (ch_fault[g]),
            .en_act_o      (ch_en_act[g]),
            .out_o         (ch_out[g])
        );
    end

    always_comb begin
        sel_target = '0;
        sel_step   = '0;
        sel_cur    = '0;
        sel_en     = 1'b0;
        sel_busy   = 1'b0;
        sel_fault  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel_valid && sel_q == 5'(i)) begin
                sel_target = ch_target[i];
                sel_step   = ch_step[i];
                sel_cur    = ch_cur[i];
                sel_en     = ch_en[i];
                sel_busy   = ch_busy[i];
                sel_fault  = ch_fault[i];
            end
        end
        rd_word = '0;
        case (reg_idx)
            REG_SEL:    rd_word[4:0]  = sel_q;
            REG_TARGET: rd_word[11:0] = sel_target;
            REG_STEP:   rd_word[11:0] = sel_step;
            REG_CTRL:   rd_word[2:0]  = {sel_fault, sel_busy, sel_en};
            REG_CUR:    rd_word[11:0] = sel_cur;
            REG_FRAME:  rd_word       = {frame_num_q, frame_cnt_q};
            default:    rd_word       = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q       <= '0;
            frame_cnt_q <= '0;
            frame_num_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            frame_cnt_q <= frame_cnt_d;
            frame_num_q <= frame_num_d;
            rvalid_q    <= avs_csr_read && hit;
            rdata_q     <= (avs_csr_read && hit) ? CSR_DWIDTH'(rd_word) : '0;
        end
    end

    assign pmux_en_o             = ch_en_act;
    assign pmux_dir_o            = ch_en_act;
    assign pmux_out_o            = ch_out;
    assign avs_csr_readdata      = rdata_q;
    assign avs_csr_readdatavalid = rvalid_q;
    assign avs_csr_waitrequest   = 1'b0;

endmodule

// File: doc/evo_pwm_bank.md
Name: evo_pwm_bank

Overview:
Parametrised multi-channel servo/PWM generator XB, the successor to the fixed-count servo XB. It drives NUM_CH pins through the pmux triplet and is programmed over the shared Avalon-MM CSR bus. Per channel it adds a pulse-width ramp (slew limit), frame-boundary-synchronous updates and target clamping. It sits inside the XB wrapper, with outputs OR-merged onto the CSR bus and its triplet mapped onto a port.

Parameters:
NUM_CH, 16, number of channels, legal 1..32.
BASE_ADDR, 6'h20, CSR word address of register 0.
FRAME_US, 20000, frame period in en1mhz ticks, legal 2600..65535.
CSR_AWIDTH, 6, CSR address width.
CSR_DWIDTH, 32, CSR data width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
en1mhz  in  1  one-clk strobe at 1 MHz
pmux_dir_o  out  NUM_CH  pin direction, 1 = output
pmux_out_o  out  NUM_CH  pulse level
pmux_en_o  out  NUM_CH  pin claim
pmux_in_i  in  NUM_CH  pin readback, used only with the fault feature
avs_csr_address  in  CSR_AWIDTH  word address
avs_csr_read  in  1  read strobe
avs_csr_write  in  1  write strobe
avs_csr_writedata  in  CSR_DWIDTH  write data
avs_csr_readdata  out  CSR_DWIDTH  read data, 0 when not valid
avs_csr_readdatavalid  out  1  read response
avs_csr_waitrequest  out  1  tied 0

Behaviour:
- Reset: async, active-high. All outputs are 0 immediately. Registers: SEL=0, TARGET/CUR=1500, STEP=0, EN=0, frame_cnt=0.
- Register map (offset from BASE_ADDR):
  - +0 SEL[4:0]: channel index.
  - +1 TARGET[11:0]: pulse width in us for channel SEL.
  - +2 STEP[11:0]: maximum change in us per frame; 0 means jump straight to target.
  - +3 CTRL: bit0 EN (R/W); bit1 BUSY (RO, CUR != TARGET); bit2 FAULT (RO, W1C).
  - +4 CUR[11:0]: RO, current width.
  - +5 FRAME: RO, frame_cnt in [15:0], frame number in [31:16] (wraps).
- TARGET writes are clamped to the range 500..2500 before storage.
- If SEL >= NUM_CH: writes to +1..+3 are ignored and reads return 0. A SEL write stores only [4:0].
- CSR reads: readdatavalid and readdata are asserted exactly 1 clk after a read that hits BASE_ADDR..BASE_ADDR+5. Otherwise both are 0, as the OR-bus requires.
- CSR writes take effect on the write clk. A simultaneous read and write to the same register returns the old value.
- Frame counter: increments on en1mhz and wraps at FRAME_US-1 to 0. The frame-start event is the en1mhz tick on which the counter wraps to 0.
- At frame start, for each channel:
  - en_act <= EN.
  - CUR moves toward TARGET by min(STEP, |TARGET-CUR|). If STEP=0, CUR <= TARGET.
- Pulse output: out = en_act & (frame_cnt < CUR). It is registered (1 clk after the counter update). This gives exactly CUR us high per frame.
- TARGET, STEP and EN writes made mid-frame never change the current pulse. There are no runt or stretched pulses.
- A channel disabled mid-pulse finishes the current frame.
- pmux_en_o = pmux_dir_o = en_act. When en_act=0, pmux_out_o is 0.
- Reset mid-pulse forces the pin low and releases the claim immediately.

Optional Feature:
EVO_PWM_BANK_FAULT_EN
- Defined:
  - pmux_in_i is double-flop synchronised.
  - On each en1mhz tick, with en_act=1, a synced pin value that differs from the out value driven 2 ticks earlier increments a 2-bit per-channel mismatch count.
  - A count of 3 sets FAULT sticky and forces en_act=0 at the next clk. The channel then stays off until FAULT is cleared (W1C) and a frame start occurs.
  - Any matching tick clears the count.
- Undefined: pmux_in_i is unused, FAULT reads 0 and W1C has no effect.

Decomposition:
- Package evo_pwm_bank_pkg holds:
  - pw_t (logic [11:0]);
  - register offset localparams REG_SEL..REG_FRAME;
  - MIN_US=500, MAX_US=2500, RESET_US=1500.
- Sub-module evo_pwm_bank_ch holds per-channel TARGET/STEP/EN/CUR, the ramp, the pulse compare and the fault logic. It is instantiated NUM_CH times by generate.
- The top level holds the CSR decode, SEL, frame counter and readback mux.

Test Plan (FRAME_US=3000, NUM_CH=4):
1. Reset, then SEL=2, TARGET=1000, EN=1 -> from the next frame start, pin 2 is high for exactly 1000 en1mhz ticks per 3000. Pins 0, 1 and 3 have en_o=0.
2. TARGET writes of 100 and 4000 -> TARGET reads back 500 and 2500 respectively.
3. CUR=1000, STEP=200, TARGET=1500 -> CUR reads 1200, 1400, 1500 on successive frames. BUSY=1 until 1500 is reached.
4. TARGET write of 2000 at frame_cnt=1200 while CUR=1500 -> the current pulse ends at 1500. The next frame applies 2000 (STEP=0).
5. SEL=7 (invalid), write TARGET=800 -> no channel changes. The read returns 0 with readdatavalid 1 clk after the read. An address outside the map gives readdatavalid=0 and readdata=0.
6. FAULT_EN defined: hold pmux_in_i[1]=0 while channel 1 is driving high -> FAULT=1 after 3 ticks and en_o[1]=0. W1C of FAULT re-enables the channel at the next frame start. Assert reset mid-pulse -> all outputs are 0 asynchronously.
